// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI register controller.
// Contents:
//   state_e     - controller FSM state encoding
//   CMD_RD_BIT  - command byte bit that selects read (1) or write (0)
//   ADDR_W      - register address width; the command byte's low bits carry the start address
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_WRITE = 3'd2,
        ST_FETCH = 3'd3,
        ST_SEND  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam int CMD_RD_BIT = 7;
    localparam int ADDR_W     = 7;

endpackage

// File: rtl/spi_addr_counter.sv
// spi_addr_counter: register address pointer with load, increment and wrap.
// Ports:
//   clock, reset          - system clock, synchronous active-high reset (pointer -> 0)
//   load, load_addr       - load the start address taken from a command byte (wins over inc)
//   inc                   - advance by one, wrapping from REG_COUNT-1 to 0
//   addr                  - current address
//   in_range              - high when addr < REG_COUNT
module spi_addr_counter
    import spi_pkg::*;
#(
    parameter int REG_COUNT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              in_range
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(REG_COUNT - 1);

    logic [ADDR_W-1:0] addr_q, addr_d;

    // An out-of-range start address simply counts upward; only the last valid
    // register wraps back to zero.
    always_comb begin
        addr_d = load ? load_addr
               : inc  ? ((addr_q == LAST) ? '0 : addr_q + ADDR_W'(1))
               : addr_q;
    end

    always_ff @(posedge clock) begin
        if (reset) addr_q <= '0;
        else       addr_q <= addr_d;
    end

    assign addr     = addr_q;
    assign in_range = 32'(addr_q) < REG_COUNT;

endmodule

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: SPI command decoder driving a byte-wide register file.
// Ports:
//   clock, reset                     - system clock, synchronous active-high reset
//   cs_active                        - chip select (already synchronised); low aborts to IDLE
//   rx_valid, rx_data, rx_ready      - received bytes: command byte, then write data or dummies
//   tx_valid, tx_data, tx_ready      - read data back to the SPI front end
//   reg_addr, reg_wr_en,
//   reg_wr_data, reg_rd_data         - register file port; reg_rd_data is combinational from reg_addr
//   busy                             - FSM not in IDLE
//   error                            - out-of-range access seen in the current transaction
// Build option:
//   SPI_REG_CTRL_BURST_EN defined   - unlimited bursts with address auto-increment and wrap
//   SPI_REG_CTRL_BURST_EN undefined - one data byte per transaction, then DONE until cs falls
module spi_reg_ctrl
    import spi_pkg::*;
#(
    parameter int REG_COUNT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cs_active,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_wr_en,
    output logic [7:0]        reg_wr_data,
    input  logic [7:0]        reg_rd_data,
    output logic              busy,
    output logic              error
);

`ifdef SPI_REG_CTRL_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    state_e      state_q, state_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        wr_pend_q, wr_pend_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        error_q, error_d;
    logic        addr_load, addr_inc, addr_ok;
    logic        rx_hs, tx_hs;

    assign rx_ready = state_q inside {ST_CMD, ST_WRITE, ST_SEND, ST_DONE};
    assign rx_hs    = rx_valid & rx_ready;
    assign tx_hs    = tx_valid_q & tx_ready;

    spi_addr_counter #(.REG_COUNT(REG_COUNT)) u_addr (
        .clock     (clock),
        .reset     (reset),
        .load      (addr_load),
        .load_addr (rx_data[ADDR_W-1:0]),
        .inc       (addr_inc),
        .addr      (reg_addr),
        .in_range  (addr_ok)
    );

    // A write is accepted into wr_pend_q and issued as reg_wr_en the following
    // cycle; in burst mode the address advances on that same pulse edge, so a
    // byte accepted during the pulse lands on the next address.
    always_comb begin
        state_d    = state_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        wr_pend_d  = 1'b0;
        wr_data_d  = wr_data_q;
        error_d    = error_q | (wr_pend_q & ~addr_ok);
        addr_load  = 1'b0;
        addr_inc   = BURST && wr_pend_q;
        if (!cs_active) begin
            // Chip select release beats any coincident byte handshake.
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_CMD;
                    error_d = 1'b0;
                end
                ST_CMD: if (rx_hs) begin
                    addr_load = 1'b1;
                    state_d   = rx_data[CMD_RD_BIT] ? ST_FETCH : ST_WRITE;
                end
                ST_WRITE: if (rx_hs) begin
                    wr_pend_d = 1'b1;
                    wr_data_d = rx_data;
                    state_d   = BURST ? ST_WRITE : ST_DONE;
                end
                ST_FETCH: begin
                    tx_data_d  = addr_ok ? reg_rd_data : 8'h00;
                    tx_valid_d = 1'b1;
                    error_d    = error_q | ~addr_ok;
                    state_d    = ST_SEND;
                end
                ST_SEND: if (tx_hs) begin
                    tx_valid_d = 1'b0;
                    addr_inc   = BURST;
                    state_d    = BURST ? ST_FETCH : ST_DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            wr_pend_q  <= 1'b0;
            wr_data_q  <= 8'h00;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            wr_pend_q  <= wr_pend_d;
            wr_data_q  <= wr_data_d;
            error_q    <= error_d;
        end
    end

    // The pulse is masked by reset so an aborting reset cycle never writes.
    assign reg_wr_en   = wr_pend_q & addr_ok & ~reset;
    assign reg_wr_data = wr_data_q;
    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign busy        = state_q != ST_IDLE;
    assign error       = error_q;

endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 SHALL have parameter REG_COUNT, default 16, number of addressable 8-bit registers (1..128).
REQ-002 SHALL have port clock  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port cs_active  in  1  SPI chip select asserted, already synchronised to clock.
REQ-005 SHALL have ports rx_valid in 1, rx_data in 8, rx_ready out 1: received-byte stream from the SPI front end.
REQ-006 SHALL have ports tx_valid out 1, tx_data out 8, tx_ready in 1: byte stream to the SPI front end.
REQ-007 SHALL have ports reg_addr out 7, reg_wr_en out 1, reg_wr_data out 8, reg_rd_data in 8: register file access; reg_rd_data is combinational from reg_addr.
REQ-008 SHALL have ports busy out 1 (state not IDLE) and error out 1 (out-of-range access seen in current transaction).

Function
REQ-009 SHALL implement FSM states IDLE, CMD, WRITE, FETCH, SEND, DONE.
REQ-010 SHALL transition IDLE->CMD on the first cycle cs_active is high; error clears on this transition.
REQ-011 SHALL hold rx_ready high in CMD, WRITE, SEND, DONE and low in IDLE, FETCH; a byte transfers when rx_valid and rx_ready are both high.
REQ-012 SHALL decode the command byte as bit7 = 1 read / 0 write, bits6:0 = start address, loaded into reg_addr.
REQ-013 SHALL go CMD->WRITE on a write command and CMD->FETCH on a read command.
REQ-014 SHALL, in WRITE, pulse reg_wr_en for exactly one cycle, the cycle after each accepted byte, with reg_wr_data = that byte and reg_addr = current address.
REQ-015 SHALL, in FETCH, register reg_rd_data into tx_data, assert tx_valid, and move to SEND one cycle later.
REQ-016 SHALL, in SEND, hold tx_valid and tx_data stable until tx_ready; on handshake advance the address and return to FETCH.
REQ-017 SHALL accept and discard rx bytes in SEND and DONE (full-duplex dummy bytes).
REQ-018 SHALL advance the address by 1 after each data byte, wrapping from REG_COUNT-1 to 0.
REQ-019 SHALL, for address >= REG_COUNT, set error, suppress reg_wr_en and return tx_data = 0x00.
REQ-020 SHALL return to IDLE the cycle after cs_active falls, from any state, dropping tx_valid and any pending write pulse not yet issued.
REQ-021 SHALL give cs_active deassertion priority over a coincident rx or tx handshake; that byte is discarded.
REQ-022 SHALL take a CMD->... transition and a write pulse in the same cycle never; the first write pulse follows the first data byte.

Reset
REQ-023 SHALL on reset force state IDLE, reg_addr 0, rx_ready 0, tx_valid 0, tx_data 0x00, reg_wr_en 0, reg_wr_data 0x00, busy 0, error 0.
REQ-024 SHALL abort a transaction when reset is asserted mid-operation, with no write pulse issued in the reset cycle.

Configuration
REQ-025 SHALL use macro SPI_REG_CTRL_BURST_EN.
REQ-026 SHALL, with SPI_REG_CTRL_BURST_EN defined, allow unlimited burst length with address auto-increment and wrap per REQ-018.
REQ-027 SHALL, without SPI_REG_CTRL_BURST_EN, go to DONE after one data byte (write) or one tx handshake (read), with no address increment, until cs_active falls.

Structure
REQ-028 SHALL place the FSM state encoding, command-bit index (7) and address width (7) in shared package spi_pkg.
REQ-029 SHALL implement the address load, increment and wrap in one sub-module spi_addr_counter.

Verification
REQ-030 Write burst: cs high, rx 0x03,0xAA,0xBB -> reg_wr_en pulses at addr 3 data 0xAA, addr 4 data 0xBB.
REQ-031 Read with backpressure: regs[5]=0x5A, rx 0x85, tx_ready low 4 cycles -> tx_data 0x5A held stable, then a single handshake, reg_addr 6.
REQ-032 Wrap: REG_COUNT=16, write cmd 0x0F, 2 data bytes -> writes at addr 15 then 0.
REQ-033 Out of range: write cmd 0x20 with REG_COUNT=16 -> error 1, no reg_wr_en; read cmd 0xA0 -> tx_data 0x00.
REQ-034 Abort: cs_active falls while tx_valid high -> next cycle IDLE, tx_valid 0, busy 0.
REQ-035 Non-burst build: write cmd 0x02, data 0x11,0x22 -> one write (addr 2, 0x11); 0x22 discarded in DONE.
